clock_rate_controller: RTL

//  Front-panel speed controller for the digital clock's divider. Turns three raw buttons (up/down/default) into a

---
 rtl/clock_rate_controller_pkg.sv | 50 +++++
 rtl/button_debouncer.sv | 49 ++++
 rtl/clock_rate_controller.sv | 97 +++++++++
 3 files changed

// File: rtl/clock_rate_controller_pkg.sv
// Shared definitions for the front-panel clock-rate controller.
//   - rate encodings RATE_1HZ..RATE_1000HZ
//   - FSM state type (S_IDLE, S_SETTLE)
//   - button lane indices into the packed button vectors
//   - rate_to_switch: registered one-hot switch pattern for a rate
//   - next_rate: priority (default > up > down) and saturating step
package clock_rate_controller_pkg;

   localparam logic [1:0] RATE_1HZ    = 2'd0;
   localparam logic [1:0] RATE_10HZ   = 2'd1;
   localparam logic [1:0] RATE_100HZ  = 2'd2;
   localparam logic [1:0] RATE_1000HZ = 2'd3;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_SETTLE = 1'b1
   } state_t;

   localparam int NUM_BTN     = 3;
   localparam int BTN_UP      = 0;
   localparam int BTN_DOWN    = 1;
   localparam int BTN_DEFAULT = 2;

   // {x1000, x100, x10}
   function automatic logic [2:0] rate_to_switch(input logic [1:0] rate);
      logic [2:0] sw;
      case (rate)
         RATE_10HZ:   sw = 3'b001;
         RATE_100HZ:  sw = 3'b010;
         RATE_1000HZ: sw = 3'b100;
         default:     sw = 3'b000;
      endcase
      return sw;
   endfunction

   // Saturating step; never wraps 3->0 or 0->3.
   function automatic logic [1:0] next_rate(input logic [1:0] rate,
                                            input logic [NUM_BTN-1:0] press);
      logic [1:0] nr;
      nr = rate;
      if (press[BTN_DEFAULT])
         nr = RATE_1HZ;
      else if (press[BTN_UP])
         nr = (rate == RATE_1000HZ) ? RATE_1000HZ : rate + 2'd1;
      else if (press[BTN_DOWN])
         nr = (rate == RATE_1HZ) ? RATE_1HZ : rate - 2'd1;
      return nr;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchroniser + debouncer for one raw push button.
//   clk, rst   : system clock, async active-high reset
//   btn_raw    : raw asynchronous button level
//   btn_level  : debounced level
//   btn_press  : one-cycle pulse when btn_level rises 0->1 (no pulse on release)
// Raw edge to btn_press is 2 + DEBOUNCE_CYCLES cycles for a clean edge.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync0, sync1;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync0     <= 1'b0;
         sync1     <= 1'b0;
         cnt       <= '0;
         btn_level <= 1'b0;
         btn_press <= 1'b0;
      end else begin
         sync0     <= btn_raw;
         sync1     <= sync0;
         btn_press <= 1'b0;
         // Any sample matching the current level (a bounce) restarts the count.
         if (sync1 != btn_level) begin
            if (cnt == CNT_MAX) begin
               btn_level <= sync1;
               btn_press <= sync1;
               cnt       <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/clock_rate_controller.sv
// Front-panel speed controller for the clock divider.
//   clk, rst                          : 100 MHz clock, async active-high reset
//   btn_up, btn_down, btn_default     : raw asynchronous buttons
//   switch_x10/x100/x1000             : registered one-hot divider selects
//   rate_sel                          : 0=1Hz 1=10Hz 2=100Hz 3=1000Hz
//   busy                              : high while settling after a rate change
//   limit                             : one-cycle pulse on a saturated press
module clock_rate_controller
   import clock_rate_controller_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int SETTLE_CYCLES   = 100_000,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_default,
   output logic       switch_x10,
   output logic       switch_x100,
   output logic       switch_x1000,
   output logic [1:0] rate_sel,
   output logic       busy,
   output logic       limit
);

   localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES - 1);

   logic [NUM_BTN-1:0] btn_raw, btn_level, btn_press, press;
   logic [1:0]         nxt;
   state_t             state;
   logic [CNT_W-1:0]   settle_cnt;

   assign btn_raw = {btn_default, btn_down, btn_up};

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      button_debouncer #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_db (
         .clk       (clk),
         .rst       (rst),
         .btn_raw   (btn_raw[i]),
         .btn_level (btn_level[i]),
         .btn_press (btn_press[i])
      );
   end

   // A press is only honoured while its debounced level is still high.
   assign press = btn_press & btn_level;
   assign nxt   = next_rate(rate_sel, press);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         settle_cnt   <= '0;
         rate_sel     <= RATE_1HZ;
         switch_x10   <= 1'b0;
         switch_x100  <= 1'b0;
         switch_x1000 <= 1'b0;
         busy         <= 1'b0;
         limit        <= 1'b0;
      end else begin
         limit <= 1'b0;
         case (state)
            S_IDLE: begin
               if (|press) begin
                  if (nxt != rate_sel) begin
                     // Rate and switches load together: no intermediate code.
                     rate_sel <= nxt;
                     {switch_x1000, switch_x100, switch_x10} <= rate_to_switch(nxt);
                     state      <= S_SETTLE;
                     settle_cnt <= '0;
                     busy       <= 1'b1;
                  end else if (!press[BTN_DEFAULT]) begin
                     // Default at 1 Hz is a no-op, not a rejected press.
                     limit <= 1'b1;
                  end
               end
            end
            S_SETTLE: begin
               // Presses here are dropped, not queued.
               if (settle_cnt == SETTLE_MAX) begin
                  state      <= S_IDLE;
                  busy       <= 1'b0;
                  settle_cnt <= '0;
               end else begin
                  settle_cnt <= settle_cnt + CNT_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
